// File: rtl/pip_bpu_pkg.sv
// Shared constants for the next-PC predictor: opcodes, sequential-PC step,
// reset polarity, BHT counter encodings and the link-register test.
package pip_bpu_pkg;

  localparam logic [4:0]  OP_JAL    = 5'b11011;
  localparam logic [4:0]  OP_JALR   = 5'b11001;
  localparam logic [4:0]  OP_BRANCH = 5'b11000;
  localparam int          NEXTPC    = 4;
  localparam logic [31:0] ZEROWORD  = 32'h0000_0000;
  localparam logic        RST_ACT   = 1'b0;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/pip_ras.sv
// Circular return-address stack. A full stack overwrites its oldest entry;
// pop+push in one cycle replaces the top in place.
module pip_ras
  import pip_bpu_pkg::*;
#(
  parameter int RAS_DEPTH = 4,
  parameter int PC_W      = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(RAS_DEPTH);

  logic [PC_W-1:0]  stack_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_top;
  logic [PTR_W:0]   cnt_q, cnt_d;

  assign ptr_top = ptr_q - PTR_ONE;
  assign top     = stack_q[ptr_top];
  assign empty   = (cnt_q == '0);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push && !(pop && !empty)) begin
      ptr_d = ptr_q + PTR_ONE;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    end else if (pop && !push && !empty) begin
      ptr_d = ptr_top;
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACT) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (push && pop && !empty) stack_q[ptr_top] <= push_data;
      else if (push)             stack_q[ptr_q]   <= push_data;
    end
  end

endmodule

// File: rtl/pip_bpu.sv
// IF-stage next-PC predictor: JAL direct, Bxx via untagged 2-bit BHT,
// JALR via RAS with register-file fallback. Prediction is combinational.
module pip_bpu
  import pip_bpu_pkg::*;
#(
  parameter int         PC_W      = 64,
  parameter int         BHT_DEPTH = 64,
  parameter int         RAS_DEPTH = 4,
  parameter logic [1:0] BHT_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [PC_W-1:0] pc_i,
  input  logic [31:0]     inst,
  input  logic [PC_W-1:0] x1_data,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  output logic [PC_W-1:0] pc_o,
  output logic            pred_taken,
  output logic            pip_ena,
  output logic [4:0]      x1_addr,
  output logic            x1_ena,
  output logic            ras_hit
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [4:0]      rd, rs1;
  logic            inst_ok, is_jal, is_jalr, is_br;
  logic [PC_W-1:0] imm_j, imm_b, imm_i, pc_seq, jalr_tgt;
  logic            unused_bits;

  assign rd      = inst[11:7];
  assign rs1     = inst[19:15];
  assign x1_addr = rs1;
  assign inst_ok = (inst[1:0] == 2'b11);
  assign is_jal  = inst_ok && (inst[6:2] == OP_JAL);
  assign is_jalr = inst_ok && (inst[6:2] == OP_JALR);
  assign is_br   = inst_ok && (inst[6:2] == OP_BRANCH);

  assign imm_j = {{(PC_W-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_b = {{(PC_W-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_i = {{(PC_W-12){inst[31]}}, inst[31:20]};

  assign pc_seq   = pc_i + PC_W'(NEXTPC);
  assign jalr_tgt = x1_data + imm_i;
  assign unused_bits = ^{inst[14:12], upd_pc, ZEROWORD};

  // BHT: untagged, predict reads the pre-update counter
  logic [1:0]       bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] pred_idx, upd_idx;
  logic [1:0]       pred_ctr, upd_ctr, upd_ctr_d;

  assign pred_idx = pc_i[IDX_W+1:2];
  assign upd_idx  = upd_pc[IDX_W+1:2];
  assign pred_ctr = bht_q[pred_idx];
  assign upd_ctr  = bht_q[upd_idx];

  always_comb begin
    upd_ctr_d = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != ST) upd_ctr_d = upd_ctr + 2'd1;
    end else begin
      if (upd_ctr != SNT) upd_ctr_d = upd_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACT) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BHT_INIT;
    end else if (upd_valid) begin
      bht_q[upd_idx] <= upd_ctr_d;
    end
  end

  // RAS control from rd/rs1 link hints
  logic            ras_pop_req, ras_push_req;
  logic            ras_push, ras_pop, ras_empty;
  logic [PC_W-1:0] ras_top;

  assign ras_pop_req  = is_jalr && is_link(rs1) && (!is_link(rd) || (rd != rs1));
  assign ras_push_req = (is_jal || is_jalr) && is_link(rd);
  assign ras_push     = if_valid && ras_push_req;
  assign ras_pop      = if_valid && ras_pop_req;

  pip_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_W      (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  logic [PC_W-1:0] pc_nxt;
  logic            taken_nxt, hit_nxt, x1en_nxt;
  logic            in_rst;

  always_comb begin
    pc_nxt    = pc_seq;
    taken_nxt = 1'b0;
    hit_nxt   = 1'b0;
    x1en_nxt  = 1'b0;
    if (is_jal) begin
      pc_nxt    = pc_i + imm_j;
      taken_nxt = 1'b1;
    end else if (is_br) begin
      if (pred_ctr[1]) begin
        pc_nxt    = pc_i + imm_b;
        taken_nxt = 1'b1;
      end
    end else if (is_jalr) begin
      taken_nxt = 1'b1;
      if (ras_pop_req && !ras_empty) begin
        pc_nxt  = ras_top;
        hit_nxt = 1'b1;
      end else begin
        pc_nxt   = {jalr_tgt[PC_W-1:1], 1'b0};
        x1en_nxt = 1'b1;
      end
    end
  end

  assign in_rst     = (rst == RST_ACT);
  assign pc_o       = in_rst ? '0   : pc_nxt;
  assign pred_taken = in_rst ? 1'b0 : taken_nxt;
  assign ras_hit    = in_rst ? 1'b0 : hit_nxt;
  assign x1_ena     = in_rst ? 1'b0 : x1en_nxt;
  assign pip_ena    = in_rst ? 1'b0 : is_br;

endmodule

// File: tb/tb_pip_bpu.sv
// Scoreboard bench for pip_bpu: expected predictions are queued as each
// fetch is driven and compared against the combinational outputs.
module tb_pip_bpu;

  localparam int PC_W = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            if_valid = 1'b0;
  logic [PC_W-1:0] pc_i = '0;
  logic [31:0]     inst = '0;
  logic [PC_W-1:0] x1_data = 64'h8000_1235;
  logic            upd_valid = 1'b0;
  logic [PC_W-1:0] upd_pc = '0;
  logic            upd_taken = 1'b0;
  logic [PC_W-1:0] pc_o;
  logic            pred_taken, pip_ena, x1_ena, ras_hit;
  logic [4:0]      x1_addr;

  pip_bpu #(.PC_W(PC_W), .BHT_DEPTH(64), .RAS_DEPTH(4), .BHT_INIT(2'b01)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .pc_i(pc_i), .inst(inst),
    .x1_data(x1_data), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .pc_o(pc_o), .pred_taken(pred_taken), .pip_ena(pip_ena), .x1_addr(x1_addr),
    .x1_ena(x1_ena), .ras_hit(ras_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           tag;
    logic [PC_W-1:0] pc;
    logic            pt, hit, x1en, pip;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [12:0] i);
    return {i[12], i[10:5], 5'd0, 5'd0, 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] i);
    return {i[20], i[10:1], i[11], i[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] i);
    return {i, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic expect_out(input string tag, input logic [PC_W-1:0] pc,
                            input logic pt, input logic hit, input logic x1en, input logic pip);
    exp_t e;
    e.tag = tag; e.pc = pc; e.pt = pt; e.hit = hit; e.x1en = x1en; e.pip = pip;
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    e = sb_q.pop_front();
    chk({e.tag, ".pc_o"},       pc_o,       e.pc);
    chk({e.tag, ".pred_taken"}, pred_taken, e.pt);
    chk({e.tag, ".ras_hit"},    ras_hit,    e.hit);
    chk({e.tag, ".x1_ena"},     x1_ena,     e.x1en);
    chk({e.tag, ".pip_ena"},    pip_ena,    e.pip);
  endtask

  task automatic step(input string tag, input logic [PC_W-1:0] pc, input logic [31:0] ins,
                      input logic uv, input logic [PC_W-1:0] upc, input logic ut,
                      input logic [PC_W-1:0] epc, input logic ept, input logic ehit,
                      input logic ex1, input logic epip);
    @(negedge clk);
    if_valid = 1'b1; pc_i = pc; inst = ins;
    upd_valid = uv; upd_pc = upc; upd_taken = ut;
    expect_out(tag, epc, ept, ehit, ex1, epip);
    #2;
    compare_out();
  endtask

  task automatic fetch(input string tag, input logic [PC_W-1:0] pc, input logic [31:0] ins,
                       input logic [PC_W-1:0] epc, input logic ept, input logic ehit,
                       input logic ex1, input logic epip);
    step(tag, pc, ins, 1'b0, '0, 1'b0, epc, ept, ehit, ex1, epip);
  endtask

  task automatic train(input string tag, input logic [PC_W-1:0] upc, input logic ut);
    step(tag, 64'h9000_0000, NOP, 1'b1, upc, ut, 64'h9000_0004, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [31:0] beq40, ret_x1, call_x1;

  initial begin
    beq40   = enc_b(13'h040);
    ret_x1  = enc_jalr(5'd0, 5'd1, 12'h000);
    call_x1 = enc_j(5'd1, 21'h00100);

    // outputs forced low while in reset, even for a JAL
    fetch("rst_hold", 64'h8000_0100, call_x1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;

    fetch("beq_init", 64'h8000_0000, beq40, 64'h8000_0004, 1'b0, 1'b0, 1'b0, 1'b1);
    train("tr_t1", 64'h8000_0000, 1'b1);
    train("tr_t2", 64'h8000_0000, 1'b1);
    fetch("beq_st", 64'h8000_0000, beq40, 64'h8000_0040, 1'b1, 1'b0, 1'b0, 1'b1);
    train("tr_n1", 64'h8000_0000, 1'b0);
    fetch("beq_wt", 64'h8000_0000, beq40, 64'h8000_0040, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) train("tr_n", 64'h8000_0000, 1'b0);
    fetch("beq_snt", 64'h8000_0000, beq40, 64'h8000_0004, 1'b0, 1'b0, 1'b0, 1'b1);
    train("tr_n5", 64'h8000_0000, 1'b0);
    train("tr_sat_t1", 64'h8000_0000, 1'b1);
    fetch("beq_sat0", 64'h8000_0000, beq40, 64'h8000_0004, 1'b0, 1'b0, 1'b0, 1'b1);
    train("tr_sat_t2", 64'h8000_0000, 1'b1);
    fetch("beq_wt2", 64'h8000_0000, beq40, 64'h8000_0040, 1'b1, 1'b0, 1'b0, 1'b1);

    // same-index update and predict: no bypass, then visible next cycle
    step("same_cyc", 64'h8000_0010, beq40, 1'b1, 64'h8000_0010, 1'b1,
         64'h8000_0014, 1'b0, 1'b0, 1'b0, 1'b1);
    fetch("same_next", 64'h8000_0010, beq40, 64'h8000_0050, 1'b1, 1'b0, 1'b0, 1'b1);
    fetch("alias", 64'h8000_0110, beq40, 64'h8000_0150, 1'b1, 1'b0, 1'b0, 1'b1);

    fetch("jal_call", 64'h8000_0100, call_x1, 64'h8000_0200, 1'b1, 1'b0, 1'b0, 1'b0);
    fetch("jalr_ret", 64'h8000_0200, ret_x1, 64'h8000_0104, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("x1_addr", x1_addr, 5'd1);
    fetch("other", 64'h8000_0300, NOP, 64'h8000_0304, 1'b0, 1'b0, 1'b0, 1'b0);

    // five nested calls into a 4-deep RAS, then five returns
    for (int i = 0; i < 5; i++) begin
      logic [PC_W-1:0] p;
      p = 64'h8000_2000 + 64'(i) * 64'h100;
      fetch("nest_call", p, call_x1, p + 64'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 4; i >= 1; i--) begin
      logic [PC_W-1:0] p;
      p = 64'h8000_2000 + 64'(i) * 64'h100 + 64'h4;
      fetch("nest_ret", 64'h8000_3000, ret_x1, p, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    fetch("ret_empty", 64'h8000_3000, ret_x1, 64'h8000_1234, 1'b1, 1'b0, 1'b1, 1'b0);

    // three pushes, then asynchronous reset between clock edges
    for (int i = 0; i < 3; i++) begin
      logic [PC_W-1:0] p;
      p = 64'h8000_4000 + 64'(i) * 64'h10;
      fetch("pre_rst_call", p, call_x1, p + 64'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    pc_i = 64'h8000_3000; inst = ret_x1; upd_valid = 1'b0;
    #1;
    expect_out("pre_rst_hit", 64'h8000_4024, 1'b1, 1'b1, 1'b0, 1'b0);
    compare_out();
    rst = 1'b0;
    #1;
    expect_out("async_rst", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    compare_out();
    @(negedge clk); rst = 1'b1;
    fetch("post_rst_ret", 64'h8000_3000, ret_x1, 64'h8000_1234, 1'b1, 1'b0, 1'b1, 1'b0);
    fetch("post_rst_beq", 64'h8000_0000, beq40, 64'h8000_0004, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
